// File: rtl/dac_wr_arbiter.sv
// Round-robin arbiter sharing one DAC SPI write port among NUM_REQ requesters.
// Optional `DAC_WR_ARBITER_DEDUP_EN skips writes that repeat the last code.
module dac_wr_arbiter #(
    parameter int         NUM_REQ      = 2,
    parameter int         CODE_WIDTH   = 16,
    parameter logic [7:0] CMD_PREFIX   = 8'h00,
    parameter int         BUSY_TIMEOUT = 15
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*CODE_WIDTH-1:0] code_i,
    output logic [NUM_REQ-1:0]            done_o,
    output logic                          busy_o,
    output logic [8+CODE_WIDTH-1:0]       spi_data_o,
    output logic                          spi_wre_o,
    input  logic                          spi_rdy_i,
    output logic                          err_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DW = 8 + CODE_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         win_q, win_d;
    logic [DW-1:0]         data_q, data_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic [IW-1:0]         pick;
    logic                  pick_vld;
    logic [CODE_WIDTH-1:0] pick_code;
    logic [NUM_REQ-1:0]    pick_oh;
    logic [NUM_REQ-1:0]    win_oh;
    logic [7:0]            cnt_inc;

`ifdef DAC_WR_ARBITER_DEDUP_EN
    logic [CODE_WIDTH-1:0] last_code_q, last_code_d;
    logic                  last_valid_q, last_valid_d;
`endif

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] a,
                                               input int b);
        int s;
        s = int'(a) + b;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[IW-1:0];
    endfunction

    // Lowest offset from the pointer wins, so scan offsets high to low.
    always_comb begin
        pick     = ptr_q;
        pick_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[wrap_inc(ptr_q, i)]) begin
                pick     = wrap_inc(ptr_q, i);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        pick_code = code_i[int'(pick)*CODE_WIDTH +: CODE_WIDTH];
        pick_oh   = '0;
        pick_oh[pick] = 1'b1;
        win_oh    = '0;
        win_oh[win_q] = 1'b1;
        cnt_inc   = cnt_q + 8'd1;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        data_d  = data_q;
        done_d  = '0;
        cnt_d   = cnt_q;
        err_d   = err_q;
`ifdef DAC_WR_ARBITER_DEDUP_EN
        last_code_d  = last_code_q;
        last_valid_d = last_valid_q;
`endif
        unique case (state_q)
            IDLE: begin
                // No new grant while a done pulse is still on the outputs.
                if (done_q == '0 && pick_vld) begin
`ifdef DAC_WR_ARBITER_DEDUP_EN
                    if (last_valid_q && pick_code == last_code_q) begin
                        done_d = pick_oh;
                        ptr_d  = wrap_inc(pick, 1);
                    end else
`endif
                    if (spi_rdy_i) begin
                        win_d   = pick;
                        data_d  = {CMD_PREFIX, pick_code};
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!spi_rdy_i) begin
                    state_d = WAIT_DONE;
                end else if (cnt_inc == 8'(BUSY_TIMEOUT)) begin
                    err_d   = 1'b1;
                    done_d  = win_oh;
                    ptr_d   = wrap_inc(win_q, 1);
                    state_d = IDLE;
`ifdef DAC_WR_ARBITER_DEDUP_EN
                    last_valid_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_DONE: begin
                if (spi_rdy_i) begin
                    done_d  = win_oh;
                    ptr_d   = wrap_inc(win_q, 1);
                    state_d = IDLE;
`ifdef DAC_WR_ARBITER_DEDUP_EN
                    last_code_d  = data_q[CODE_WIDTH-1:0];
                    last_valid_d = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            data_q  <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef DAC_WR_ARBITER_DEDUP_EN
            last_code_q  <= '0;
            last_valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            data_q  <= data_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef DAC_WR_ARBITER_DEDUP_EN
            last_code_q  <= last_code_d;
            last_valid_q <= last_valid_d;
`endif
        end
    end

    assign done_o     = done_q;
    assign busy_o     = (state_q != IDLE);
    assign spi_wre_o  = (state_q == ISSUE);
    assign spi_data_o = data_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_dac_wr_arbiter.sv
// Scoreboard bench for dac_wr_arbiter with a behavioural SPI master model.
// Dedup checks run only when DAC_WR_ARBITER_DEDUP_EN is defined.
module tb_dac_wr_arbiter;

    localparam int NR = 2;
    localparam int CW = 16;
    localparam int TO = 15;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR*CW-1:0]  code;
    logic [NR-1:0]     done_o;
    logic              busy_o;
    logic [8+CW-1:0]   spi_data_o;
    logic              spi_wre_o;
    logic              spi_rdy;
    logic              err_o;

    dac_wr_arbiter #(
        .NUM_REQ(NR), .CODE_WIDTH(CW), .CMD_PREFIX(8'h00), .BUSY_TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .code_i(code),
        .done_o(done_o), .busy_o(busy_o), .spi_data_o(spi_data_o),
        .spi_wre_o(spi_wre_o), .spi_rdy_i(spi_rdy), .err_o(err_o)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_wre_cyc = 0;
    logic never_drop = 1'b0;
    logic [8+CW-1:0] exp_wr[$];
    logic [NR-1:0]   exp_done[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // SPI master model: rdy drops the cycle after the strobe, returns 30 later.
    initial begin
        int phase;
        int mcnt;
        phase = 0;
        mcnt = 0;
        spi_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                spi_rdy = 1'b1;
                phase = 0;
            end else begin
                case (phase)
                    0: if (spi_wre_o && !never_drop) phase = 1;
                    1: begin spi_rdy = 1'b0; mcnt = 30; phase = 2; end
                    default: begin
                        mcnt--;
                        if (mcnt == 0) begin spi_rdy = 1'b1; phase = 0; end
                    end
                endcase
            end
        end
    end

    // Monitor: pops expected strobes and done pulses as they appear.
    initial begin
        logic prev_wre;
        prev_wre = 1'b0;
        forever begin
            @(negedge clk);
            if (spi_wre_o) begin
                last_wre_cyc = cyc;
                n_chk++;
                if (prev_wre) begin
                    n_fail++;
                    $display("FAIL wre_consec: got two strobes, want one");
                end
                n_chk++;
                if (exp_wr.size() == 0) begin
                    n_fail++;
                    $display("FAIL wre_unexp: got data %h, want no strobe", spi_data_o);
                end else begin
                    logic [8+CW-1:0] w;
                    w = exp_wr.pop_front();
                    if (spi_data_o !== w) begin
                        n_fail++;
                        $display("FAIL spi_data: got %h want %h", spi_data_o, w);
                    end
                end
            end
            if (done_o != '0) begin
                n_chk++;
                if (exp_done.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_unexp: got %b want 00", done_o);
                end else begin
                    logic [NR-1:0] d;
                    d = exp_done.pop_front();
                    if (done_o !== d) begin
                        n_fail++;
                        $display("FAIL done: got %b want %b", done_o, d);
                    end
                end
            end
            prev_wre = spi_wre_o;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic wait_done(input int k, input string nm);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done_o[k] && t < 600);
        n_chk++;
        if (!done_o[k]) begin
            n_fail++;
            $display("FAIL %s: done_o timeout got %b want bit %0d", nm, done_o, k);
        end
    endtask

    task automatic wait_rdy_low(input string nm);
        int t;
        t = 0;
        while (spi_rdy && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_chk++;
        if (spi_rdy) begin
            n_fail++;
            $display("FAIL %s: rdy never fell got 1 want 0", nm);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0;
        code = '0;
        do_reset();
        chk("rst_done", 32'(done_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_wre", 32'(spi_wre_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_data", 32'(spi_data_o), 32'h0);

        // single request
        exp_wr.push_back(24'h001234);
        exp_done.push_back(2'b01);
        code = {16'h0000, 16'h1234};
        req = 2'b01;
        wait_done(0, "single");
        req = '0;
        @(negedge clk);
        chk("single_busy", 32'(busy_o), 32'h0);

        // contention from a fresh pointer
        do_reset();
        code = {16'h5555, 16'hAAAA};
        for (int i = 0; i < 2; i++) begin
            exp_wr.push_back(24'h00AAAA);
            exp_done.push_back(2'b01);
            exp_wr.push_back(24'h005555);
            exp_done.push_back(2'b10);
        end
        req = 2'b11;
        for (int i = 0; i < 2; i++) begin
            wait_done(0, "cont0");
            wait_done(1, "cont1");
        end
        req = '0;

        // code change after grant
        code = {16'h0000, 16'h0010};
        exp_wr.push_back(24'h000010);
        exp_done.push_back(2'b01);
        req = 2'b01;
        wait_rdy_low("chg");
        code = {16'h0000, 16'h0020};
        wait_done(0, "chg");
        req = '0;

        // busy timeout
        never_drop = 1'b1;
        code = {16'h0BEE, 16'h0020};
        exp_wr.push_back(24'h000BEE);
        exp_done.push_back(2'b10);
        req = 2'b10;
        wait_done(1, "tmo");
        chk("tmo_lat", 32'(cyc - last_wre_cyc), 32'(TO + 1));
        chk("tmo_err", 32'(err_o), 32'h1);
        req = '0;
        never_drop = 1'b0;
        code = {16'h0BEE, 16'h0777};
        exp_wr.push_back(24'h000777);
        exp_done.push_back(2'b01);
        req = 2'b01;
        wait_done(0, "post_tmo");
        req = '0;
        chk("err_sticky", 32'(err_o), 32'h1);

        // reset during WAIT_DONE
        code = {16'h0000, 16'h4321};
        exp_wr.push_back(24'h004321);
        req = 2'b01;
        wait_rdy_low("mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        @(negedge clk);
        chk("mid_done", 32'(done_o), 32'h0);
        chk("mid_busy", 32'(busy_o), 32'h0);
        chk("mid_err", 32'(err_o), 32'h0);
        chk("mid_data", 32'(spi_data_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        code = {16'h2222, 16'h1111};
        exp_wr.push_back(24'h001111);
        exp_done.push_back(2'b01);
        exp_wr.push_back(24'h002222);
        exp_done.push_back(2'b10);
        req = 2'b11;
        wait_done(0, "rr_rst0");
        req = 2'b10;
        wait_done(1, "rr_rst1");
        req = '0;

`ifdef DAC_WR_ARBITER_DEDUP_EN
        do_reset();
        code = {16'h0100, 16'h0000};
        exp_wr.push_back(24'h000100);
        exp_done.push_back(2'b10);
        req = 2'b10;
        wait_done(1, "dd_first");
        req = '0;
        @(negedge clk);
        exp_done.push_back(2'b10);
        req = 2'b10;
        wait_done(1, "dd_skip");
        req = '0;
        do_reset();
        exp_wr.push_back(24'h000100);
        exp_done.push_back(2'b10);
        req = 2'b10;
        wait_done(1, "dd_after_rst");
        req = '0;
`endif

        repeat (5) @(negedge clk);
        chk("wr_q_empty", 32'(exp_wr.size()), 32'h0);
        chk("done_q_empty", 32'(exp_done.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
